fft_seq_ctrl: RTL and testbench
===============================

// Module: fft_seq_ctrl
// PURPOSE
//  Sequencer for the in-place radix-2 DIT FFT core. Steps the stage/butterfly
//  counters, emits butterfly read addresses and twiddle indices, and delays the
//  addresses to match butterfly latency to produce write-back addresses.
//  Inserts drain bubbles between stages to prevent read-after-write hazards.
//  Drives one frame per start/done handshake. Sits between data RAM, twiddle ROM and butterfly.
// PARAMETERS
//  LOG2N   3  log2 of FFT points (N = 1<<LOG2N), >= 2
//  BF_LAT  2  butterfly latency: issue cycle to write cycle, >= 1
// PORTS
//  clk        in   1           clock, all logic on rising edge
//  reset      in   1           synchronous, active-high
//  start      in   1           frame request, sampled in IDLE only
//  stall      in   1           freezes RUN/DRAIN progress and the write pipeline
//  busy       out  1           high in RUN and DRAIN
//  done       out  1           one-cycle pulse at frame end
//  stage      out  SW          current stage 0..LOG2N-1, SW=$clog2(LOG2N+1)
//  rd_en      out  1           butterfly issue this cycle
//  rd_addr_a  out  LOG2N       upper-leg read address
//  rd_addr_b  out  LOG2N       lower-leg read address
//  tw_idx     out  LOG2N-1     twiddle ROM index
//  wr_en      out  1           write-back strobe
//  wr_addr_a  out  LOG2N       upper-leg write address
//  wr_addr_b  out  LOG2N       lower-leg write address
// BEHAVIOUR
//  - Reset (synchronous, active-high; clock clk): state=IDLE, counters=0, write pipeline cleared.
//    All outputs 0 in the next cycle. Reset mid-frame aborts with no done pulse.
//  - FSM: IDLE -start-> RUN; RUN -last butterfly of stage issued-> DRAIN;
//    DRAIN -BF_LAT cycles elapsed-> RUN (stage+1), or DONE if stage==LOG2N-1;
//    DONE -> IDLE unconditionally. start outside IDLE is ignored.
//  - Timing: start high at cycle T -> RUN from T+1, first rd_en at T+1.
//  - Issue rule in RUN with stall=0: rd_en=1, one butterfly b (0..N/2-1) per cycle.
//    With s=stage and h=1<<s:
//      rd_addr_a = ((b>>s)<<(s+1)) | (b&(h-1))
//      rd_addr_b = rd_addr_a + h
//      tw_idx    = (b&(h-1)) << (LOG2N-1-s)
//  - stall=1 in RUN/DRAIN: rd_en=0, wr_en=0. Counters, drain counter and write
//    pipeline are frozen. Progress resumes with no loss or duplicates.
//    stall has no effect in IDLE/DONE.
//  - Write pipeline: BF_LAT-deep shift of {valid,addr_a,addr_b}, advancing on
//    non-stalled cycles only. The issue at RUN cycle k writes at non-stalled
//    cycle k+BF_LAT (wr_en=1, wr_addr=issued rd_addr).
//  - Drain: the last write of a stage lands in the last DRAIN cycle, so the
//    next stage's first read sees the updated RAM.
//  - Addresses/tw_idx are 0 whenever the corresponding strobe is 0.
//    stage holds its value through DRAIN and is 0 in IDLE.
//  - Busy span without stall: LOG2N*(N/2+BF_LAT) cycles. done is in cycle T+1+span.
// TESTING
//  - N=8, BF_LAT=2, start@0, no stall -> rd_en at 1-4, 7-10, 13-16.
//    busy for cycles 1-18; done only at 19; busy=0 at 19.
//  - Same run, check addresses:
//    stage0 (a,b)=(0,1)(2,3)(4,5)(6,7), tw=0,0,0,0
//    stage1 (0,2)(1,3)(4,6)(5,7), tw=0,2,0,2
//    stage2 (0,4)(1,5)(2,6)(3,7), tw=0,1,2,3
//  - Same run, check write-back: wr_en at 3-6, 9-12, 15-18, with wr_addr equal to
//    the rd_addr issued 2 cycles earlier. Checker: no read of an address with a
//    pending write.
//  - stall high for cycles 3-5 -> no rd_en/wr_en in 3-5; issue sequence unchanged;
//    every event shifts +3; done at 22.
//  - reset at cycle 8 -> cycle 9: busy=0, rd_en=0, wr_en=0, stage=0, no done pulse.
//    start@10 -> clean full frame, done at 29.
//  - start held high for 40 cycles -> back-to-back frames, done at 19 and 39;
//    start pulse while busy=1 causes no restart.

Source files
------------

// File: rtl/fft_seq_ctrl.sv
// Sequencer for an in-place radix-2 DIT FFT: walks stages and butterflies, emits
// read/twiddle addresses, and delays them through a stall-aware write-back line.
module fft_seq_ctrl #(
  parameter  int LOG2N  = 3,
  parameter  int BF_LAT = 2,
  localparam int SW     = $clog2(LOG2N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  output logic             busy,
  output logic             done,
  output logic [SW-1:0]    stage,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_idx,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b
);
  localparam int N  = 1 << LOG2N;
  localparam int BW = LOG2N - 1;
  localparam int DW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(N / 2 - 1);
  localparam logic [DW-1:0] D_LAST = DW'(BF_LAT - 1);
  localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                       state;
  logic [BW-1:0]                bcnt;
  logic [DW-1:0]                dcnt;
  logic                         hold;
  logic [BF_LAT-1:0]            vld_pipe;
  logic [BF_LAT-1:0][LOG2N-1:0] pipe_a, pipe_b;
  logic [LOG2N-1:0]             bx, half, lo_mask, addr_a;
  logic [BW-1:0]                tw_full;

  // stall only freezes the frame while it is in flight
  assign hold  = stall & ((state == RUN) | (state == DRAIN));
  assign busy  = (state == RUN) | (state == DRAIN);
  assign done  = (state == DONE);
  assign rd_en = (state == RUN) & ~stall;

  // butterfly b splits into group (b>>s) and offset (b&(h-1)); a zero is
  // inserted at bit s to form the upper-leg address
  always_comb begin
    bx      = LOG2N'(bcnt);
    half    = LOG2N'(1) << stage;
    lo_mask = half - LOG2N'(1);
    addr_a  = ((bx >> stage) << (stage + SW'(1))) | (bx & lo_mask);
    tw_full = BW'((bx & lo_mask) << (S_LAST - stage));
  end

  assign rd_addr_a = rd_en ? addr_a        : '0;
  assign rd_addr_b = rd_en ? addr_a + half : '0;
  assign tw_idx    = rd_en ? tw_full       : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      stage <= '0;
      bcnt  <= '0;
      dcnt  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          stage <= '0;
          bcnt  <= '0;
        end
        RUN: if (!stall) begin
          if (bcnt == B_LAST) begin
            state <= DRAIN;
            dcnt  <= '0;
          end else begin
            bcnt <= bcnt + BW'(1);
          end
        end
        // BF_LAT bubbles let the last write of the stage land before the next read
        DRAIN: if (!stall) begin
          if (dcnt == D_LAST) begin
            dcnt <= '0;
            bcnt <= '0;
            if (stage == S_LAST) begin
              state <= DONE;
              stage <= '0;
            end else begin
              state <= RUN;
              stage <= stage + SW'(1);
            end
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      pipe_a   <= '0;
      pipe_b   <= '0;
    end else if (!hold) begin
      vld_pipe[0] <= rd_en;
      pipe_a[0]   <= rd_addr_a;
      pipe_b[0]   <= rd_addr_b;
      for (int i = 1; i < BF_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        pipe_a[i]   <= pipe_a[i-1];
        pipe_b[i]   <= pipe_b[i-1];
      end
    end
  end

  assign wr_en     = vld_pipe[BF_LAT-1] & ~hold;
  assign wr_addr_a = wr_en ? pipe_a[BF_LAT-1] : '0;
  assign wr_addr_b = wr_en ? pipe_b[BF_LAT-1] : '0;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Scoreboard bench for fft_seq_ctrl: a step-count reference model predicts the
// per-cycle control outputs and the full read/write address sequence of each frame.
module tb_fft_seq_ctrl;
  localparam int LOG2N  = 3;
  localparam int BF_LAT = 2;
  localparam int N      = 1 << LOG2N;
  localparam int SW     = $clog2(LOG2N + 1);
  localparam int BLK    = N / 2 + BF_LAT;
  localparam int SPAN   = LOG2N * BLK;

  logic             clk = 0, reset = 1, start = 0, stall = 0;
  logic             busy, done, rd_en, wr_en;
  logic [SW-1:0]    stage;
  logic [LOG2N-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [LOG2N-2:0] tw_idx;

  fft_seq_ctrl #(.LOG2N(LOG2N), .BF_LAT(BF_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .busy(busy), .done(done), .stage(stage),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_idx(tw_idx),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  typedef struct {int s; int a; int b; int tw;} rd_t;
  typedef struct {int a; int b;} wr_t;
  typedef struct {bit busy; bit done; bit rd; bit wr; int s;} ctl_t;

  rd_t  rd_q[$];
  wr_t  wr_q[$];
  ctl_t ctl_q[$];

  // Expected butterfly order: groups of span 2h, offset j inside each group
  task automatic push_frame();
    for (int s = 0; s < LOG2N; s++) begin
      int h;
      h = 1 << s;
      for (int g = 0; g < N; g += 2 * h)
        for (int j = 0; j < h; j++) begin
          rd_q.push_back('{s: s, a: g + j, b: g + j + h, tw: j * (N / (2 * h))});
          wr_q.push_back('{a: g + j, b: g + j + h});
        end
    end
  endtask

  // Reference model: a frame is SPAN progress steps, one per non-stalled busy cycle
  bit mon_on = 0;
  int m_st = 0;  // 0 idle, 1 busy, 2 done
  int m_p  = 0;
  always @(negedge clk) if (mon_on) begin
    ctl_t e;
    e = '{busy: 0, done: 0, rd: 0, wr: 0, s: 0};
    if (m_st == 1) begin
      e.busy = 1;
      e.s    = m_p / BLK;
      e.rd   = !stall && (m_p % BLK) < N / 2;
      e.wr   = !stall && (m_p % BLK) >= BF_LAT;
    end else if (m_st == 2) begin
      e.done = 1;
    end
    ctl_q.push_back(e);
    if (reset) m_st = 0;
    else case (m_st)
      0: if (start) begin push_frame(); m_st = 1; m_p = 0; end
      1: if (!stall) begin m_p++; if (m_p == SPAN) m_st = 2; end
      default: m_st = 0;
    endcase
  end

  logic [N-1:0] pend = '0;
  int done_cnt = 0, bsy_cnt = 0;
  int done_cyc[$];
  always @(negedge clk) if (mon_on) begin
    ctl_t e;
    rd_t  r;
    wr_t  w;
    #1;
    if (ctl_q.size() == 0) begin
      total++; bad++;
      $display("FAIL ctl_underrun cyc=%0d got=empty want=entry", cyc);
    end else begin
      e = ctl_q.pop_front();
      chk("busy", busy, e.busy);
      chk("done", done, e.done);
      chk("rd_en", rd_en, e.rd);
      chk("wr_en", wr_en, e.wr);
      chk("stage", stage, e.s);
    end
    if (wr_en) begin
      if (wr_q.size() == 0) begin
        total++; bad++;
        $display("FAIL wr_unexpected cyc=%0d got=write want=none", cyc);
      end else begin
        w = wr_q.pop_front();
        chk("wr_addr_a", wr_addr_a, w.a);
        chk("wr_addr_b", wr_addr_b, w.b);
        pend[w.a] = 1'b0;
        pend[w.b] = 1'b0;
      end
    end else chk("wr_addr_idle", {wr_addr_a, wr_addr_b}, 0);
    if (rd_en) begin
      if (rd_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rd_unexpected cyc=%0d got=read want=none", cyc);
      end else begin
        r = rd_q.pop_front();
        chk("rd_stage", stage, r.s);
        chk("rd_addr_a", rd_addr_a, r.a);
        chk("rd_addr_b", rd_addr_b, r.b);
        chk("tw_idx", tw_idx, r.tw);
        chk("raw_hazard", {pend[rd_addr_a], pend[rd_addr_b]}, 0);
        pend[rd_addr_a] = 1'b1;
        pend[rd_addr_b] = 1'b1;
      end
    end else chk("rd_addr_idle", {rd_addr_a, rd_addr_b, tw_idx}, 0);
    if (busy) bsy_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc.push_back(cyc);
      chk("rd_q_left", rd_q.size(), 0);
      chk("wr_q_left", wr_q.size(), 0);
    end
    if (reset) begin
      rd_q.delete();
      wr_q.delete();
      pend = '0;
    end
  end

  task automatic step(input bit st, input bit sl, input bit rs);
    @(posedge clk);
    #1;
    start = st;
    stall = sl;
    reset = rs;
  endtask

  task automatic idle_n(input int n);
    repeat (n) step(0, 0, 0);
  endtask

  initial begin
    int t0, d0, b0, k, ak;
    bit ab;
    step(0, 0, 1);
    step(0, 1, 1);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stage", stage, 0);
    chk("rst_rd_wr", {rd_en, wr_en}, 0);
    step(0, 0, 0);
    mon_on = 1;
    idle_n(2);

    // plain frame
    d0 = done_cnt; b0 = bsy_cnt;
    step(1, 0, 0); t0 = cyc;
    idle_n(24);
    chk("plain_done_cnt", done_cnt - d0, 1);
    chk("plain_done_cyc", done_cyc[$] - t0, 19);
    chk("plain_busy_span", bsy_cnt - b0, SPAN);

    // stall during cycles 3..5 of the frame
    d0 = done_cnt; b0 = bsy_cnt;
    step(1, 0, 0); t0 = cyc;
    idle_n(2);
    repeat (3) step(0, 1, 0);
    idle_n(22);
    chk("stall_done_cnt", done_cnt - d0, 1);
    chk("stall_done_cyc", done_cyc[$] - t0, 22);
    chk("stall_busy_span", bsy_cnt - b0, SPAN + 3);

    // abort by reset at cycle 8, restart at 10
    d0 = done_cnt;
    step(1, 0, 0); t0 = cyc;
    idle_n(7);
    step(0, 0, 1);
    step(0, 0, 0);
    chk("abort_no_done", done_cnt - d0, 0);
    step(1, 0, 0);
    idle_n(24);
    chk("abort_done_cnt", done_cnt - d0, 1);
    chk("abort_done_cyc", done_cyc[$] - t0, 29);

    // start held high: back-to-back frames
    d0 = done_cnt;
    step(1, 0, 0); t0 = cyc;
    repeat (39) step(1, 0, 0);
    idle_n(5);
    chk("b2b_done_cnt", done_cnt - d0, 2);
    chk("b2b_done1", done_cyc[$-1] - t0, 19);
    chk("b2b_done2", done_cyc[$] - t0, 39);

    // randomized frames: random stall, stray starts, occasional abort
    for (int f = 0; f < 30; f++) begin
      idle_n($urandom_range(0, 3));
      ab = ($urandom_range(0, 5) == 0);
      ak = $urandom_range(2, 20);
      d0 = done_cnt;
      step(1, $urandom_range(0, 1) == 1, 0);
      k = 0;
      while (done_cnt == d0 && k < 200) begin
        step($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, ab && k == ak);
        k++;
        if (ab && k > ak + 2) break;
      end
      if (!ab && done_cnt == d0) begin
        total++; bad++;
        $display("FAIL frame_timeout cyc=%0d got=no_done want=done", cyc);
      end
    end
    idle_n(30);
    chk("final_rd_q", rd_q.size(), 0);
    chk("final_wr_q", wr_q.size(), 0);
    chk("final_idle", {busy, done, rd_en, wr_en}, 0);
    mon_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
